cell_entry_controller: RTL

Sequencer that places a player's digit into the 9x9 Sudoku board RAM at the current cursor cell from `board_control`. It checks the request's range, rejects writes to clue cells, and scans the 27 row/column/box peers for a duplicate digit. It commits the write only when no conflict exists, and returns a one-cycle result for the display and status logic.

---
 rtl/cell_entry_controller.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/cell_entry_controller.sv
`default_nettype none
// ============================================================================
// Module      : cell_entry_controller
// Description : Places a player's digit into the 9x9 Sudoku board RAM at the
//               cursor cell. It range-checks the request, refuses clue cells,
//               scans the 27 row/column/box peers for a duplicate and commits
//               the write only when no conflict is found.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_entry_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] grid_i,
    input  logic [3:0] grid_j,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    output logic [6:0] ram_addr,
    input  logic [4:0] ram_rd_data,
    output logic       ram_we,
    output logic [4:0] ram_wr_data,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic [3:0] conflict_i,
    output logic [3:0] conflict_j
);

    localparam logic [2:0] C_IDLE      = 3'd0;
    localparam logic [2:0] C_TGT_RD    = 3'd1;
    localparam logic [2:0] C_TGT_CHK   = 3'd2;
    localparam logic [2:0] C_SCAN      = 3'd3;
    localparam logic [2:0] C_SCAN_LAST = 3'd4;
    localparam logic [2:0] C_WRITE     = 3'd5;
    localparam logic [2:0] C_DONE      = 3'd6;

    localparam logic [1:0] C_RES_WRITTEN  = 2'd0;
    localparam logic [1:0] C_RES_CONFLICT = 2'd1;
    localparam logic [1:0] C_RES_FIXED    = 2'd2;
    localparam logic [1:0] C_RES_RANGE    = 2'd3;

    localparam logic [4:0] C_LAST_PEER = 5'd26;

    logic [2:0] r_state;
    logic [2:0] w_next_state;

    logic [3:0] r_tgt_i;
    logic [3:0] r_tgt_j;
    logic [3:0] r_digit;
    logic [4:0] r_k;
    logic [3:0] r_prev_i;
    logic [3:0] r_prev_j;
    logic [1:0] r_result;
    logic [3:0] r_conf_i;
    logic [3:0] r_conf_j;

    logic       w_out_of_range;
    logic [3:0] w_box_i;
    logic [3:0] w_box_j;
    logic [3:0] w_m;
    logic [3:0] w_peer_i;
    logic [3:0] w_peer_j;
    logic [6:0] w_tgt_addr;
    logic [6:0] w_peer_addr;
    logic       w_hit;
    logic       w_conflict;

    // Request is rejected before any RAM access if coordinates or digit are illegal
    assign w_out_of_range = (grid_i > 4'd8) || (grid_j > 4'd8) || (digit > 4'd9);

    // Top-left corner of the 3x3 box that holds the target cell
    assign w_box_i = (r_tgt_i >= 4'd6) ? 4'd6 : ((r_tgt_i >= 4'd3) ? 4'd3 : 4'd0);
    assign w_box_j = (r_tgt_j >= 4'd6) ? 4'd6 : ((r_tgt_j >= 4'd3) ? 4'd3 : 4'd0);

    // Box index m = k-18; only the low nibble matters since k is 18..26 here
    assign w_m = r_k[3:0] - 4'd2;

    // Coordinates of peer k: row sweep, then column sweep, then box sweep
    always_comb begin
        w_peer_i = r_tgt_i;
        w_peer_j = r_tgt_j;
        if (r_k < 5'd9) begin
            w_peer_j = r_k[3:0];
        end else if (r_k < 5'd18) begin
            w_peer_i = r_k[3:0] - 4'd9;
        end else if (w_m < 4'd3) begin
            w_peer_i = w_box_i;
            w_peer_j = w_box_j + w_m;
        end else if (w_m < 4'd6) begin
            w_peer_i = w_box_i + 4'd1;
            w_peer_j = w_box_j + (w_m - 4'd3);
        end else begin
            w_peer_i = w_box_i + 4'd2;
            w_peer_j = w_box_j + (w_m - 4'd6);
        end
    end

    // Linear address i*9 + j, computed as i*8 + i + j
    assign w_tgt_addr  = {r_tgt_i, 3'b000} + {3'b000, r_tgt_i} + {3'b000, r_tgt_j};
    assign w_peer_addr = {w_peer_i, 3'b000} + {3'b000, w_peer_i} + {3'b000, w_peer_j};

    // Read data belongs to the peer presented last cycle; the target itself never conflicts
    assign w_hit = (ram_rd_data[3:0] == r_digit) &&
                   ((r_prev_i != r_tgt_i) || (r_prev_j != r_tgt_j));
    assign w_conflict = w_hit && (((r_state == C_SCAN) && (r_k != 5'd0)) ||
                                  (r_state == C_SCAN_LAST));

    // State register; reset aborts any request in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_IDLE: begin
                if (digit_valid) begin
                    w_next_state = w_out_of_range ? C_DONE : C_TGT_RD;
                end
            end
            C_TGT_RD: w_next_state = C_TGT_CHK;
            C_TGT_CHK: begin
                if (ram_rd_data[4]) begin
                    w_next_state = C_DONE;
                end else if (r_digit == 4'd0) begin
                    w_next_state = C_WRITE;
                end else begin
                    w_next_state = C_SCAN;
                end
            end
            C_SCAN: begin
                if (w_conflict) begin
                    w_next_state = C_DONE;
                end else if (r_k == C_LAST_PEER) begin
                    w_next_state = C_SCAN_LAST;
                end
            end
            C_SCAN_LAST: w_next_state = w_conflict ? C_DONE : C_WRITE;
            C_WRITE:     w_next_state = C_DONE;
            C_DONE:      w_next_state = C_IDLE;
            default:     w_next_state = C_IDLE;
        endcase
    end

    // Output decode: RAM address/strobe and status flags from the current state
    always_comb begin
        ram_addr = 7'd0;
        ram_we   = 1'b0;
        busy     = (r_state != C_IDLE);
        done     = (r_state == C_DONE);
        case (r_state)
            C_TGT_RD: ram_addr = w_tgt_addr;
            C_SCAN:   ram_addr = w_peer_addr;
            C_WRITE: begin
                ram_addr = w_tgt_addr;
                ram_we   = 1'b1;
            end
            default: ram_addr = 7'd0;
        endcase
    end

    // Request latch, scan index and result registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tgt_i  <= 4'd0;
            r_tgt_j  <= 4'd0;
            r_digit  <= 4'd0;
            r_k      <= 5'd0;
            r_prev_i <= 4'd0;
            r_prev_j <= 4'd0;
            r_result <= C_RES_WRITTEN;
            r_conf_i <= 4'd0;
            r_conf_j <= 4'd0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (digit_valid) begin
                        r_tgt_i <= grid_i;
                        r_tgt_j <= grid_j;
                        r_digit <= digit;
                        r_k     <= 5'd0;
                        if (w_out_of_range) begin
                            r_result <= C_RES_RANGE;
                        end
                    end
                end
                C_TGT_CHK: begin
                    r_k <= 5'd0;
                    if (ram_rd_data[4]) begin
                        r_result <= C_RES_FIXED;
                    end
                end
                C_SCAN: begin
                    r_prev_i <= w_peer_i;
                    r_prev_j <= w_peer_j;
                    r_k      <= r_k + 5'd1;
                end
                C_WRITE: r_result <= C_RES_WRITTEN;
                default: ;
            endcase
            if (w_conflict) begin
                r_result <= C_RES_CONFLICT;
                r_conf_i <= r_prev_i;
                r_conf_j <= r_prev_j;
            end
        end
    end

    assign ram_wr_data = {1'b0, r_digit};
    assign result      = r_result;
    assign conflict_i  = r_conf_i;
    assign conflict_j  = r_conf_j;

endmodule
`default_nettype wire
